// File: rtl/m_seg_scan_reader.sv
// m_seg_scan_reader
// Reconstructs a 4-digit hexadecimal value by passively sniffing a
// multiplexed 7-segment display bus (common-anode, active-low).
//
// Ports
//   clk    : sole clock, all logic on the rising edge
//   rst    : synchronous, active-high reset
//   seg_n  : sampled cathode bus, active-low; [7] = dp, [6:0] = g..a
//   an_n   : sampled anode bus, active-low; bit i selects digit i (3 = MSD)
//   value  : last complete frame, nibble i = digit i
//   dp     : last complete frame decimal points, active-high
//   valid  : one-cycle pulse when value/dp/err update
//   err    : last published frame contained an undecodable digit
//   stale  : capture timeout flag (0 unless SEG_READER_TIMEOUT_EN)
//
// Handshake: valid is a single-cycle strobe with no back-pressure; value,
// dp and err change only in the cycle valid is high and hold otherwise.
//
// Build option: define SEG_READER_TIMEOUT_EN to add the idle-capture
// watchdog (TIMEOUT_CYCLES) that drives stale and drops a partial frame.
module m_seg_scan_reader #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        err,
  output logic        stale
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  localparam logic [8:0] SETTLE_W = 9'(SETTLE_CYCLES);

  // Input register plus one-cycle-older copy for stability comparison
  logic [7:0]  seg_q, seg_p;
  logic [3:0]  an_q, an_p;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [3:0]  seen, seen_nx;
  logic [3:0]  err_bits, err_bits_nx;
  logic [15:0] shadow_val, shadow_val_nx;
  logic [3:0]  shadow_dp, shadow_dp_nx;

  logic        sel_ok;
  logic [1:0]  idx;
  logic        same_sample;
  logic        capture;
  logic        publish;
  logic        timeout_hit;
  logic [4:0]  dec;

  // Reverse 7-segment decode: {recognised, nibble}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h27: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Exactly one anode low is a selection; anything else is blanking
  always_comb begin
    sel_ok = 1'b1;
    idx    = 2'd0;
    case (an_q)
      4'hE: idx = 2'd0;
      4'hD: idx = 2'd1;
      4'hB: idx = 2'd2;
      4'h7: idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  assign same_sample = (an_q == an_p) && (seg_q == seg_p);
  assign dec         = decode(seg_q[6:0]);
  assign publish     = (seen == 4'hF);

  // Digit FSM next-state. Entering SETTLE loads the counter with 1, which
  // already satisfies a one-cycle settle requirement.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    if (!sel_ok) begin
      state_nx = ST_WAIT;
      cnt_nx   = 8'd0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (same_sample) begin
            if (({1'b0, cnt} + 9'd1) >= SETTLE_W) begin
              capture  = 1'b1;
              state_nx = ST_HELD;
            end
            cnt_nx = cnt + 8'd1;
          end else begin
            cnt_nx = 8'd1;
            if (SETTLE_W <= 9'd1) begin
              capture  = 1'b1;
              state_nx = ST_HELD;
            end
          end
        end
        ST_HELD: begin
          if (!same_sample) begin
            cnt_nx   = 8'd1;
            state_nx = ST_SETTLE;
            if (SETTLE_W <= 9'd1) begin
              capture  = 1'b1;
              state_nx = ST_HELD;
            end
          end
        end
        default: begin
          cnt_nx   = 8'd1;
          state_nx = ST_SETTLE;
          if (SETTLE_W <= 9'd1) begin
            capture  = 1'b1;
            state_nx = ST_HELD;
          end
        end
      endcase
    end
  end

  // Frame assembly. A publish or a timeout empties the frame first, so a
  // capture in the same cycle starts the next frame cleanly.
  always_comb begin
    seen_nx       = seen;
    err_bits_nx   = err_bits;
    shadow_val_nx = shadow_val;
    shadow_dp_nx  = shadow_dp;
    if (publish || timeout_hit) begin
      seen_nx     = 4'h0;
      err_bits_nx = 4'h0;
    end
    if (capture) begin
      seen_nx[idx]      = 1'b1;
      err_bits_nx[idx]  = ~dec[4];
      shadow_dp_nx[idx] = ~seg_q[7];
      // An unrecognised pattern keeps whatever nibble was there before
      if (dec[4]) shadow_val_nx[{idx, 2'b00} +: 4] = dec[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= 8'hFF;
      an_q       <= 4'hF;
      seg_p      <= 8'hFF;
      an_p       <= 4'hF;
      state      <= ST_WAIT;
      cnt        <= 8'd0;
      seen       <= 4'h0;
      err_bits   <= 4'h0;
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      value      <= 16'h0000;
      dp         <= 4'h0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      seg_q      <= seg_n;
      an_q       <= an_n;
      seg_p      <= seg_q;
      an_p       <= an_q;
      state      <= state_nx;
      cnt        <= cnt_nx;
      seen       <= seen_nx;
      err_bits   <= err_bits_nx;
      shadow_val <= shadow_val_nx;
      shadow_dp  <= shadow_dp_nx;
      valid      <= publish;
      if (publish) begin
        value <= shadow_val;
        dp    <= shadow_dp;
        err   <= |err_bits;
      end
    end
  end

`ifdef SEG_READER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;

  // Fires once, on the cycle the idle count reaches the limit
  assign timeout_hit = !capture && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      stale    <= 1'b0;
    end else begin
      if (capture)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;
      if (publish)
        stale <= 1'b0;
      else if (timeout_hit)
        stale <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign stale       = 1'b0;
`endif

endmodule

// File: tb/tb_m_seg_scan_reader.sv
// tb_m_seg_scan_reader
// Directed scoreboard bench for m_seg_scan_reader. Stimulus tasks push the
// expected frame {err, dp, value} when the completing digit is driven; an
// independent monitor pops and compares on every valid pulse.
module tb_m_seg_scan_reader;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        valid;
  logic        err;
  logic        stale;

  m_seg_scan_reader #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
    .value(value), .dp(dp), .valid(valid), .err(err), .stale(stale)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [20:0] exp_q[$];
  bit lat_armed = 1'b0;
  int t_last = 0;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got value=%h dp=%b err=%b, no frame expected", value, dp, err);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        if ({err, dp, value} !== e) begin
          errors++;
          $display("FAIL frame: got value=%h dp=%b err=%b expected value=%h dp=%b err=%b",
                   value, dp, err, e[15:0], e[19:16], e[20]);
        end
      end
      if (lat_armed) begin
        lat_armed = 1'b0;
        checks++;
        if (cyc - t_last != SETTLE + 2) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected %0d", cyc - t_last, SETTLE + 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'h0: pat = 7'h40; 4'h1: pat = 7'h79; 4'h2: pat = 7'h24; 4'h3: pat = 7'h30;
      4'h4: pat = 7'h19; 4'h5: pat = 7'h12; 4'h6: pat = 7'h02; 4'h7: pat = 7'h78;
      4'h8: pat = 7'h00; 4'h9: pat = 7'h10; 4'hA: pat = 7'h08; 4'hB: pat = 7'h03;
      4'hC: pat = 7'h27; 4'hD: pat = 7'h21; 4'hE: pat = 7'h06; default: pat = 7'h0E;
    endcase
  endfunction

  task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    hold(4'hF, 8'hFF, n);
  endtask

  function automatic logic [3:0] anode(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  task automatic digit(input int i, input logic [3:0] d, input logic dp_on, input int n);
    hold(anode(i), {~dp_on, pat(d)}, n);
  endtask

  // Scan digits 0..3; the expected frame is pushed when digit 3 is driven.
  task automatic scan4(input logic [15:0] v, input logic [3:0] dps, input int n,
                       input bit expect_frame, input bit arm);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        if (expect_frame) exp_q.push_back({1'b0, dps, v});
        if (arm) begin
          t_last    = cyc;
          lat_armed = 1'b1;
        end
      end
      digit(i, v[i*4 +: 4], dps[i], n);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    an_n  = 4'hF;
    seg_n = 8'hFF;
    @(posedge clk); #1;
    do_reset(3);
    @(negedge clk);
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_dp",    32'(dp),    32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_err",   32'(err),   32'h0);
    chk("reset_stale", 32'(stale), 32'h0);
    @(posedge clk); #1;

    // Basic scan 1,2,3,4 held 8 cycles each
    scan4(16'h4321, 4'b0000, 8, 1'b1, 1'b1);
    blank(10);
    chk("hold_value", 32'(value), 32'h4321);

    // Digit 0 held only 3 cycles: must not be captured
    hold(4'hE, 8'hC0, 3);
    blank(10);
    digit(1, 4'h5, 1'b0, 8);
    digit(2, 4'h6, 1'b0, 8);
    digit(3, 4'h7, 1'b0, 8);
    blank(10);
    exp_q.push_back({1'b0, 4'b0000, 16'h7658});
    digit(0, 4'h8, 1'b0, 8);
    blank(10);

    // Letters with a dp on digit 3
    hold(4'hE, 8'h88, 8);
    hold(4'hD, 8'h83, 8);
    hold(4'hB, 8'hA7, 8);
    exp_q.push_back({1'b0, 4'b1000, 16'hECBA});
    hold(4'h7, 8'h06, 8);
    blank(10);

    // Undecodable digit 2 keeps prior nibble C and flags err
    digit(0, 4'h1, 1'b0, 8);
    digit(1, 4'h2, 1'b0, 8);
    hold(4'hB, 8'hFF, 8);
    exp_q.push_back({1'b1, 4'b0000, 16'h3C21});
    digit(3, 4'h3, 1'b0, 8);
    blank(10);
    chk("err_hold", 32'(err), 32'h1);

    // Recapture of digit 2 within a frame clears its error
    digit(0, 4'h1, 1'b0, 8);
    hold(4'hB, 8'hFF, 8);
    digit(2, 4'h9, 1'b0, 8);
    digit(1, 4'h2, 1'b0, 8);
    exp_q.push_back({1'b0, 4'b0000, 16'h3921});
    digit(3, 4'h3, 1'b0, 8);
    blank(10);

    // Exactly SETTLE_CYCLES per digit is sufficient
    scan4(16'hDEF0, 4'b0101, SETTLE, 1'b1, 1'b1);
    blank(10);

    // Two anodes active: blanking, no capture
    hold(4'hC, 8'hF9, 20);
    blank(5);

    // Reset after three digits discards the partial frame
    digit(0, 4'h5, 1'b0, 8);
    digit(1, 4'h5, 1'b0, 8);
    digit(2, 4'h5, 1'b0, 8);
    do_reset(2);
    @(negedge clk);
    chk("midreset_value", 32'(value), 32'h0);
    chk("midreset_err",   32'(err),   32'h0);
    @(posedge clk); #1;
    blank(3);
    scan4(16'h6789, 4'b0000, 8, 1'b1, 1'b0);
    blank(10);

`ifdef SEG_READER_TIMEOUT_EN
    do_reset(2);
    blank(3);
    digit(0, 4'h1, 1'b0, 8);
    digit(1, 4'h2, 1'b0, 8);
    blank(50);
    @(negedge clk);
    chk("stale_early", 32'(stale), 32'h0);
    @(posedge clk); #1;
    blank(60);
    @(negedge clk);
    chk("stale_set", 32'(stale), 32'h1);
    @(posedge clk); #1;
    // seen was cleared: digits 2,3 alone must not complete a frame
    digit(2, 4'h3, 1'b0, 8);
    digit(3, 4'h4, 1'b0, 8);
    blank(10);
    exp_q.push_back({1'b0, 4'b0000, 16'h4321});
    digit(0, 4'h1, 1'b0, 8);
    digit(1, 4'h2, 1'b0, 8);
    digit(2, 4'h3, 1'b0, 8);
    digit(3, 4'h4, 1'b0, 8);
    blank(10);
    @(negedge clk);
    chk("stale_cleared", 32'(stale), 32'h0);
`else
    blank(200);
    @(negedge clk);
    chk("stale_tied", 32'(stale), 32'h0);
`endif

    @(posedge clk); #1;
    blank(20);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
